conv_13_mul_share_arb: RTL and testbench
========================================

// Module: conv_13_mul_share_arb
// PURPOSE
// - Shares one signed 16x8 multiplier between NUM_REQ requesters.
// - Requesters are conv-layer lanes of the conv_13 datapath.
// - Round-robin arbitration over operand requests.
// - 2-stage registered pipeline with valid/ready on both sides.
// - Each result is tagged with the requester index and returned on a single shared response bus.
// PARAMETERS
// NUM_REQ   4   number of requesters (2..16)
// ID_W      2   width of requester tag, = clog2(NUM_REQ)
// A_WIDTH   16  signed operand a width
// B_WIDTH   8   signed operand b width
// P_WIDTH   24  product width, must equal A_WIDTH+B_WIDTH
// PORTS
// ap_clk     in   1                clock, all logic rising-edge
// ap_rst_n   in   1                synchronous reset, active-low
// req_valid  in   NUM_REQ          per-requester operand valid
// req_ready  out  NUM_REQ          per-requester accept, one-hot or zero
// req_a      in   NUM_REQ*A_WIDTH  signed a operands, requester i at [i*A_WIDTH +: A_WIDTH]
// req_b      in   NUM_REQ*B_WIDTH  signed b operands, same packing
// rsp_valid  out  1                result valid
// rsp_ready  in   1                result accept
// rsp_id     out  ID_W             requester index of the result
// rsp_p      out  P_WIDTH          signed product a*b, full precision
// occupancy  out  2                number of valid pipeline stages (0..2)
// BEHAVIOUR
// - Reset (ap_rst_n=0 at a clock edge):
//   - s1_valid, s2_valid, rsp_valid, occupancy and rr_ptr all cleared to 0.
//   - req_ready is 0 while ap_rst_n=0.
//   - A reset mid-operation discards in-flight operands with no response.
// - Pipeline:
//   - S1 is the operand register: a, b, id.
//   - S2 is the product register: p, id; it drives the rsp_* ports.
// - Advance rules:
//   - adv2 = !s2_valid | rsp_ready
//   - adv1 = !s1_valid | adv2
// - Grant:
//   - When adv1=1, grant the first requester with req_valid=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[g]=1 only for the granted index; it is combinational from req_valid, rr_ptr and adv1.
//   - A transfer occurs when req_valid[i] & req_ready[i].
//   - No grant when adv1=0; all req_ready are 0.
// - rr_ptr update:
//   - After a transfer to g, rr_ptr <= (g+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
//   - rr_ptr is unchanged when there is no transfer.
// - Data movement:
//   - On adv1, S1 loads the granted operands and s1_valid <= transfer.
//   - On adv2, S2 loads p = $signed(s1_a)*$signed(s1_b) and s1_id, and s2_valid <= s1_valid.
// - Latency and throughput:
//   - Latency is 2 cycles: a transfer at edge t gives rsp_valid=1 after edge t+1.
//   - Throughput is 1 result/cycle while rsp_ready=1.
// - Stall: rsp_valid=0 -> 1 holds rsp_p and rsp_id stable until rsp_ready.
//   - With S1 and S2 both full and rsp_ready=0, no grants occur.
//   - A simultaneous rsp_ready=1 and new request with a full pipe is accepted in the same cycle (bubble-free).
// - Ordering: results leave in grant order; no reordering.
// - Width: the product is exact; -32768*-128 = 4194304 fits in 24 bits signed, so there is no saturation.
// - occupancy = s1_valid + s2_valid, registered alongside the stages.
// - Requesters must hold operands stable while req_valid=1 and req_ready=0; the arbiter does not latch ungranted requests.
// STRUCTURE
// - Shared package conv_13_mul_pkg:
//   - A_WIDTH/B_WIDTH/P_WIDTH constants.
//   - NUM_REQ default.
//   - clog2 function.
//   - typedef of the tagged result {id, p}.
// - Sub-module conv_13_mul_share_core: the combinational signed A_WIDTH x B_WIDTH multiplier (DSP48-mapped), instantiated once between S1 and S2.
// - The round-robin picker stays inline: priority rotate, find-first, unrotate.
// TESTING
// 1. Reset: hold ap_rst_n=0 for 3 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, occupancy=0 throughout.
// 2. Single request: req 2 with a=-3, b=7 -> req_ready[2]=1 at once, rsp_valid two edges later, rsp_p=-21, rsp_id=2, rr_ptr=3.
// 3. Fairness: req_valid=4'hF held, rsp_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one result/cycle.
// 4. Backpressure: rsp_ready=0 with a continuous request -> occupancy reaches 2, then req_ready=0 and rsp fields stay stable.
//    Raising rsp_ready then gives back-to-back results with no loss or duplication.
// 5. Extremes: a=-32768, b=-128 -> rsp_p=24'h400000; a=32767, b=-128 -> rsp_p=-4194176.
// 6. Reset mid-operation with occupancy=2 -> no response emerges afterwards and the first grant after reset goes to index 0.

Source files
------------

// File: rtl/conv_13_mul_pkg.sv
// Shared constants and types for the conv_13 shared multiplier.
// Operand widths, default lane count and the tagged result.
package conv_13_mul_pkg;

    localparam int A_W = 16;
    localparam int B_W = 8;
    localparam int P_W = A_W + B_W;
    localparam int NUM_REQ_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int ID_W_DEF = clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic signed [P_W-1:0] p;
    } mul_rsp_t;

endpackage

// File: rtl/conv_13_mul_share_core.sv
// Combinational signed multiplier shared by all conv_13 lanes.
// Operands are sign-extended to the full product width first.
module conv_13_mul_share_core
    import conv_13_mul_pkg::*;
#(
    parameter int AW = A_W,
    parameter int BW = B_W,
    parameter int PW = P_W
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [PW-1:0] p
);

    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;

    assign ax = {{(PW-AW){a[AW-1]}}, a};
    assign bx = {{(PW-BW){b[BW-1]}}, b};
    assign p  = ax * bx;

endmodule

// File: rtl/conv_13_mul_share_arb.sv
// Round-robin arbiter feeding one shared multiplier through a
// 2-stage valid/ready pipeline; results are tagged by lane.
module conv_13_mul_share_arb
    import conv_13_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = clog2(NUM_REQ),
    parameter int A_WIDTH = A_W,
    parameter int B_WIDTH = B_W,
    parameter int P_WIDTH = P_W
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_WIDTH-1:0]         rsp_p,
    output logic [1:0]                 occupancy
);

    logic [ID_W-1:0]           rr_ptr;
    logic                      s1_valid;
    logic signed [A_WIDTH-1:0] s1_a;
    logic signed [B_WIDTH-1:0] s1_b;
    logic [ID_W-1:0]           s1_id;
    logic                      s2_valid;
    logic signed [P_WIDTH-1:0] s2_p;
    logic [ID_W-1:0]           s2_id;
    logic [1:0]                occ_q;

    logic                      adv1;
    logic                      adv2;
    logic                      xfer;
    logic                      hit;
    logic [2*NUM_REQ-1:0]      dbl;
    logic [NUM_REQ-1:0]        rot;
    logic [ID_W-1:0]           off;
    logic [ID_W:0]             sum;
    logic [ID_W-1:0]           gnt;
    logic [ID_W-1:0]           gnt_nxt;
    logic signed [P_WIDTH-1:0] prod;
    logic                      s1_nxt;
    logic                      s2_nxt;

    assign adv2 = !s2_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Rotate so rr_ptr sits at bit 0, take the lowest hit, rotate back.
    always_comb begin
        dbl = {req_valid, req_valid};
        rot = dbl[rr_ptr +: NUM_REQ];
        hit = 1'b0;
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit = 1'b1;
                off = ID_W'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        gnt = sum[ID_W-1:0];
        req_ready = '0;
        if (ap_rst_n && adv1 && hit) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign xfer    = |(req_valid & req_ready);
    assign gnt_nxt = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    assign s1_nxt  = adv1 ? xfer : s1_valid;
    assign s2_nxt  = adv2 ? s1_valid : s2_valid;

    conv_13_mul_share_core #(
        .AW(A_WIDTH),
        .BW(B_WIDTH),
        .PW(P_WIDTH)
    ) u_core (
        .a(s1_a),
        .b(s1_b),
        .p(prod)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (adv1) begin
                s1_valid <= xfer;
                s1_a     <= req_a[gnt*A_WIDTH +: A_WIDTH];
                s1_b     <= req_b[gnt*B_WIDTH +: B_WIDTH];
                s1_id    <= gnt;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_p     <= prod;
                s2_id    <= s1_id;
            end
            if (xfer) begin
                rr_ptr <= gnt_nxt;
            end
            occ_q <= {1'b0, s1_nxt} + {1'b0, s2_nxt};
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_p     = s2_p;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_conv_13_mul_share_arb.sv
// Bench for the shared multiplier arbiter: vector table, directed
// sequences and random traffic against a queue-based model.
module tb_conv_13_mul_share_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_p;
    logic [1:0]  occupancy;

    always #5 ap_clk = ~ap_clk;

    conv_13_mul_share_arb dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_p(rsp_p),
        .occupancy(occupancy)
    );

    typedef struct {
        int id;
        int a;
        int b;
        int p;
        int nxt;
    } vec_t;

    typedef struct {
        int id;
        int p;
        int age;
    } item_t;

    vec_t  tv[5];
    item_t q[$];
    int    rr_m;
    int    last_g;
    int    total;
    int    bad;

    task automatic chk(input string name,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare against the model, advance the model.
    task automatic step(input logic rst, input logic [3:0] v,
                        input logic [63:0] a, input logic [31:0] b,
                        input logic rr);
        int    cnt;
        bit    vis;
        bit    acc;
        int    g;
        int    idx;
        item_t it;
        logic signed [15:0] sa;
        logic signed [7:0]  sb;
        @(negedge ap_clk);
        ap_rst_n  = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        cnt = q.size();
        vis = (cnt > 0) && (q[0].age >= 1);
        acc = rst && ((cnt < 2) || rr);
        g = -1;
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                idx = (rr_m + k) % 4;
                if (v[idx] && g < 0) g = idx;
            end
        end
        chk("req_ready", {28'd0, req_ready}, (g >= 0) ? (1 << g) : 0);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, vis});
        if (vis) begin
            chk("rsp_id", {30'd0, rsp_id}, q[0].id);
            chk("rsp_p", $signed(rsp_p), q[0].p);
        end
        chk("occupancy", {30'd0, occupancy}, cnt);
        last_g = g;
        if (!rst) begin
            q.delete();
            rr_m = 0;
        end else begin
            if (vis && rr) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (g >= 0) begin
                sa = a[g*16 +: 16];
                sb = b[g*8 +: 8];
                it.id  = g;
                it.p   = int'(sa) * int'(sb);
                it.age = 0;
                q.push_back(it);
                rr_m = (g + 1) % 4;
            end
        end
    endtask

    initial begin
        logic [63:0] fa;
        logic [31:0] fb;
        logic [63:0] ta;
        logic [31:0] tb;
        logic [23:0] hold_p;
        int          bp_a;

        tv[0] = '{id: 2, a: -3,     b: 7,    p: -21,      nxt: 3};
        tv[1] = '{id: 0, a: -32768, b: -128, p: 4194304,  nxt: 1};
        tv[2] = '{id: 3, a: 32767,  b: -128, p: -4194176, nxt: 0};
        tv[3] = '{id: 1, a: -1,     b: -1,   p: 1,        nxt: 2};
        tv[4] = '{id: 1, a: 100,    b: 0,    p: 0,        nxt: 2};

        total = 0;
        bad = 0;
        rr_m = 0;
        last_g = -1;
        ap_rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge ap_clk);

        for (int i = 0; i < 4; i++) begin
            fa[i*16 +: 16] = 16'(100 * (i + 1));
            fb[i*8 +: 8]   = 8'(i - 2);
        end

        // Reset held with all lanes requesting.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'hF, fa, fb, 1'b1);
            chk("rst_ready", {28'd0, req_ready}, 0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
            chk("rst_occ", {30'd0, occupancy}, 0);
        end

        // Fairness from a fresh pointer.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'hF, fa, fb, 1'b1);
            chk("fair_gnt", last_g, k % 4);
            if (k >= 2) begin
                chk("fair_valid", {31'd0, rsp_valid}, 1);
                chk("fair_id", {30'd0, rsp_id}, (k - 2) % 4);
            end
        end
        repeat (2) step(1'b1, 4'h0, fa, fb, 1'b1);

        // Single-request vectors, then the next grant with all lanes up.
        for (int i = 0; i < 5; i++) begin
            ta = '0;
            tb = '0;
            ta[tv[i].id*16 +: 16] = 16'(tv[i].a);
            tb[tv[i].id*8 +: 8]   = 8'(tv[i].b);
            step(1'b1, 4'(1 << tv[i].id), ta, tb, 1'b1);
            chk("vec_ready", {28'd0, req_ready}, 1 << tv[i].id);
            step(1'b1, 4'h0, ta, tb, 1'b1);
            chk("vec_lat1", {31'd0, rsp_valid}, 0);
            step(1'b1, 4'h0, ta, tb, 1'b1);
            chk("vec_lat2", {31'd0, rsp_valid}, 1);
            chk("vec_id", {30'd0, rsp_id}, tv[i].id);
            chk("vec_p", $signed(rsp_p), tv[i].p);
            step(1'b1, 4'hF, fa, fb, 1'b1);
            chk("vec_next", last_g, tv[i].nxt);
            repeat (2) step(1'b1, 4'h0, fa, fb, 1'b1);
        end

        // Backpressure with a single continuous requester.
        bp_a = 1;
        hold_p = '0;
        for (int k = 0; k < 12; k++) begin
            ta = '0;
            tb = '0;
            ta[15:0] = 16'(bp_a);
            tb[7:0]  = 8'd6;
            step(1'b1, 4'h1, ta, tb, (k >= 6));
            if (k >= 2 && k < 6) begin
                chk("bp_occ", {30'd0, occupancy}, 2);
                chk("bp_ready", {28'd0, req_ready}, 0);
                if (k == 2) hold_p = rsp_p;
                chk("bp_hold", {8'd0, rsp_p}, {8'd0, hold_p});
            end
            if (k >= 6) chk("bp_b2b", {31'd0, rsp_valid}, 1);
            if (last_g == 0) bp_a++;
        end
        repeat (3) step(1'b1, 4'h0, fa, fb, 1'b1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            ta = {$urandom, $urandom};
            tb = $urandom;
            step(1'b1, 4'($urandom), ta, tb,
                 ($urandom_range(0, 3) != 0));
        end
        repeat (3) step(1'b1, 4'h0, fa, fb, 1'b1);

        // Reset with a full pipe.
        repeat (3) step(1'b1, 4'hF, fa, fb, 1'b0);
        chk("mid_occ", {30'd0, occupancy}, 2);
        repeat (2) begin
            step(1'b0, 4'hF, fa, fb, 1'b0);
            chk("mid_rst_ready", {28'd0, req_ready}, 0);
        end
        repeat (3) begin
            step(1'b1, 4'h0, fa, fb, 1'b1);
            chk("mid_no_rsp", {31'd0, rsp_valid}, 0);
        end
        step(1'b1, 4'hF, fa, fb, 1'b1);
        chk("mid_first_gnt", last_g, 0);
        repeat (3) step(1'b1, 4'h0, fa, fb, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
